// File: rtl/if_id_pipe_if.sv
// Fetch-to-decode handshake bundle for the IF/ID skid register.
// The pipe itself takes the slave view; the fetch/decode environment takes the master view.
interface if_id_pipe_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;

    modport slave (
        input  in_valid,
        input  in_pc,
        input  in_instr,
        output in_ready,
        output out_valid,
        output out_pc,
        output out_instr,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_pc,
        output in_instr,
        input  in_ready,
        input  out_valid,
        input  out_pc,
        input  out_instr,
        output out_ready
    );
endinterface

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with a one-entry skid buffer, flush squash and
// saturating stall/flush performance counters.
module if_id_pipe #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    if_id_pipe_if.slave      bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [1:0]         state_q,      state_d;
    logic [PC_W-1:0]    main_pc_q,    main_pc_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    skid_pc_q,    skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [CNT_W-1:0]   stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q,  flush_cnt_d;

    logic main_vld;
    logic skid_vld;
    logic in_fire;
    logic out_fire;

    // Valid bits are carried by the state encoding so they can never disagree with it.
    assign main_vld = (state_q != ST_EMPTY);
    assign skid_vld = (state_q == ST_SKID);

    // in_ready looks only at registered state, breaking any out_ready -> in_ready path.
    assign bus.in_ready  = !skid_vld;
    assign bus.out_valid = main_vld;
    assign bus.out_pc    = main_pc_q;
    assign bus.out_instr = main_vld ? main_instr_q : NOP_INSTR;

    assign in_fire  = bus.in_valid  & bus.in_ready;
    assign out_fire = main_vld & bus.out_ready;

    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        if (flush) begin
            // Squash: data fields are left untouched, only validity is dropped.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_pc_d    = bus.in_pc;
                        main_instr_d = bus.in_instr;
                        state_d      = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_pc_d    = bus.in_pc;
                        main_instr_d = bus.in_instr;
                    end else if (in_fire) begin
                        skid_pc_d    = bus.in_pc;
                        skid_instr_d = bus.in_instr;
                        state_d      = ST_SKID;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        main_pc_d    = skid_pc_q;
                        main_instr_d = skid_instr_q;
                        state_d      = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (main_vld && !bus.out_ready) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
        if (flush && (state_q != ST_EMPTY)) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_EMPTY;
            main_pc_q    <= '0;
            main_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed bench for if_id_pipe: reset, single beat, streaming, skid, flush,
// counter saturation and asynchronous reset in SKID.
module tb_if_id_pipe;

    localparam int                 PC_W    = 32;
    localparam int                 INSTR_W = 32;
    localparam int                 CNT_W   = 4;
    localparam logic [INSTR_W-1:0] NOP     = 32'h0000_0013;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    if_id_pipe_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    if_id_pipe #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .NOP_INSTR(NOP),
        .CNT_W    (CNT_W)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (flush),
        .bus      (bus),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic rdy);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = ins;
        bus.out_ready = rdy;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        flush   = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #2;
        n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_chk++; if (bus.out_instr !== NOP) $display("FAIL rst_out_instr: got %h want %h", bus.out_instr, NOP); else n_pass++;
        n_chk++; if (bus.out_pc !== 32'h0) $display("FAIL rst_out_pc: got %h want 0", bus.out_pc); else n_pass++;
        n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); else n_pass++;
        n_chk++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) $display("FAIL rst_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt); else n_pass++;
        tick();
        #3 reset_n = 1'b1;
    endtask

    task automatic test_single();
        drive(1'b1, 32'h4, 32'h2008_0005, 1'b1);
        tick();
        n_chk++; if (bus.out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", bus.out_valid); else n_pass++;
        n_chk++; if (bus.out_pc !== 32'h4) $display("FAIL single_pc: got %h want 4", bus.out_pc); else n_pass++;
        n_chk++; if (bus.out_instr !== 32'h2008_0005) $display("FAIL single_instr: got %h want 20080005", bus.out_instr); else n_pass++;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL single_drain: got %b want 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_stream();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 32'(4 * k), 32'h1000_0000 + 32'(k), 1'b1);
            tick();
            n_chk++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * k) || bus.out_instr !== 32'h1000_0000 + 32'(k) || bus.in_ready !== 1'b1)
                $display("FAIL stream_beat%0d: got v=%b pc=%h ins=%h rdy=%b want v=1 pc=%h ins=%h rdy=1",
                         k, bus.out_valid, bus.out_pc, bus.out_instr, bus.in_ready, 4 * k, 32'h1000_0000 + k);
            else n_pass++;
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL stream_drain: got %b want 0", bus.out_valid); else n_pass++;
        n_chk++; if (stall_cnt !== 4'd0) $display("FAIL stream_stall_cnt: got %0d want 0", stall_cnt); else n_pass++;
    endtask

    task automatic test_skid();
        drive(1'b1, 32'h100, 32'hAAAA_0001, 1'b0);
        tick();
        n_chk++; if (bus.out_pc !== 32'h100 || bus.in_ready !== 1'b1) $display("FAIL skid_full: got pc=%h rdy=%b want pc=100 rdy=1", bus.out_pc, bus.in_ready); else n_pass++;
        drive(1'b1, 32'h104, 32'hAAAA_0002, 1'b0);
        tick();
        n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL skid_in_ready: got %b want 0", bus.in_ready); else n_pass++;
        n_chk++; if (bus.out_pc !== 32'h100) $display("FAIL skid_head_pc: got %h want 100", bus.out_pc); else n_pass++;
        drive(1'b1, 32'h108, 32'hAAAA_0003, 1'b0);
        tick();
        n_chk++; if (bus.in_ready !== 1'b0 || bus.out_pc !== 32'h100) $display("FAIL skid_hold: got rdy=%b pc=%h want rdy=0 pc=100", bus.in_ready, bus.out_pc); else n_pass++;
        n_chk++; if (stall_cnt !== 4'd2) $display("FAIL skid_stall_cnt: got %0d want 2", stall_cnt); else n_pass++;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        n_chk++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h104 || bus.out_instr !== 32'hAAAA_0002) $display("FAIL skid_second: got v=%b pc=%h ins=%h want v=1 pc=104 ins=aaaa0002", bus.out_valid, bus.out_pc, bus.out_instr); else n_pass++;
        n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL skid_reopen: got %b want 1", bus.in_ready); else n_pass++;
        tick();
        n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL skid_no_third: got %b want 0", bus.out_valid); else n_pass++;
        n_chk++; if (stall_cnt !== 4'd2) $display("FAIL skid_stall_final: got %0d want 2", stall_cnt); else n_pass++;
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h200, 32'hBBBB_0001, 1'b0);
        tick();
        drive(1'b1, 32'h204, 32'hBBBB_0002, 1'b0);
        tick();
        n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL flush_pre_skid: got %b want 0", bus.in_ready); else n_pass++;
        flush = 1'b1;
        drive(1'b1, 32'h208, 32'hBBBB_0003, 1'b0);
        tick();
        n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_chk++; if (bus.out_instr !== NOP) $display("FAIL flush_instr: got %h want %h", bus.out_instr, NOP); else n_pass++;
        n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); else n_pass++;
        n_chk++; if (flush_cnt !== 4'd1) $display("FAIL flush_cnt: got %0d want 1", flush_cnt); else n_pass++;
        n_chk++; if (stall_cnt !== 4'd4) $display("FAIL flush_stall_cnt: got %0d want 4", stall_cnt); else n_pass++;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL flush_discard: got %b want 0", bus.out_valid); else n_pass++;
        n_chk++; if (flush_cnt !== 4'd1) $display("FAIL flush_empty_cnt: got %0d want 1", flush_cnt); else n_pass++;
        flush = 1'b0;
    endtask

    task automatic test_stall_sat();
        drive(1'b1, 32'h400, 32'hCCCC_0001, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 19; i++) tick();
        n_chk++; if (stall_cnt !== 4'd15) $display("FAIL stall_saturate: got %0d want 15", stall_cnt); else n_pass++;
        n_chk++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h400) $display("FAIL stall_hold: got v=%b pc=%h want v=1 pc=400", bus.out_valid, bus.out_pc); else n_pass++;
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h404, 32'hCCCC_0002, 1'b0);
        tick();
        n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL areset_pre_skid: got %b want 0", bus.in_ready); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_chk++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL areset_immediate: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready); else n_pass++;
        n_chk++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) $display("FAIL areset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt); else n_pass++;
        n_chk++; if (bus.out_instr !== NOP || bus.out_pc !== 32'h0) $display("FAIL areset_data: got ins=%h pc=%h want ins=%h pc=0", bus.out_instr, bus.out_pc, NOP); else n_pass++;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        #2 reset_n = 1'b1;
        drive(1'b1, 32'h300, 32'hDDDD_0001, 1'b1);
        tick();
        n_chk++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h300) $display("FAIL areset_first_beat: got v=%b pc=%h want v=1 pc=300", bus.out_valid, bus.out_pc); else n_pass++;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL areset_drain: got %b want 0", bus.out_valid); else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_skid();
        test_flush();
        test_stall_sat();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
